dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin grant, alignment/range checking,
// single-cycle word stores, byte/half loads and read-modify-write sub-word stores.
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_rd_addr,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, LOAD, RMW_RD, RMW_WR} state_t;

  state_t      state, state_nxt;
  logic        last_gnt, last_nxt;
  logic        lat_port, lat_port_nxt;
  logic [1:0]  lat_size, lat_size_nxt;
  logic [6:0]  lat_addr, lat_addr_nxt;
  logic [15:0] lat_wdata, lat_wdata_nxt;

  logic        sel;
  logic        s_we;
  logic [1:0]  s_size;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        bad;
  logic        gnt_any, err_any, rvalid_any;
  logic [31:0] rdata_int;
  logic [31:0] shifted;
  logic [31:0] merged;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      lat_port  <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state     <= state_nxt;
      last_gnt  <= last_nxt;
      lat_port  <= lat_port_nxt;
      lat_size  <= lat_size_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_wdata <= lat_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    last_nxt      = last_gnt;
    lat_port_nxt  = lat_port;
    lat_size_nxt  = lat_size;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    gnt_any       = 1'b0;
    err_any       = 1'b0;
    rvalid_any    = 1'b0;
    rdata_int     = '0;
    mem_ren       = 1'b0;
    mem_wen       = 1'b0;
    mem_rd_addr   = '0;
    mem_wr_addr   = '0;
    mem_wr_data   = '0;

    // On a tie the port that did not win last time gets the grant.
    sel     = (p0_req && p1_req) ? ~last_gnt : p1_req;
    s_we    = sel ? p1_we    : p0_we;
    s_size  = sel ? p1_size  : p0_size;
    s_addr  = sel ? p1_addr  : p0_addr;
    s_wdata = sel ? p1_wdata : p0_wdata;

    bad = (s_size == 2'b11) ||
          (s_size == 2'b01 && s_addr[0]) ||
          (s_size == 2'b10 && s_addr[1:0] != 2'b00) ||
          (s_addr[31:7] != '0);

    shifted = mem_rd_data >> {lat_addr[1:0], 3'b000};

    merged = mem_rd_data;
    if (lat_size == 2'b00) begin
      merged[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
    end else if (lat_addr[1]) begin
      merged[31:16] = lat_wdata;
    end else begin
      merged[15:0] = lat_wdata;
    end

    case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          gnt_any  = 1'b1;
          last_nxt = sel;
          if (bad) begin
            err_any = 1'b1;
          end else if (s_we && s_size == 2'b10) begin
            mem_wen     = 1'b1;
            mem_wr_addr = {27'b0, s_addr[6:2]};
            mem_wr_data = s_wdata;
          end else begin
            // Loads and sub-word stores both start by reading the target word.
            mem_ren       = 1'b1;
            mem_rd_addr   = {27'b0, s_addr[6:2]};
            lat_port_nxt  = sel;
            lat_size_nxt  = s_size;
            lat_addr_nxt  = s_addr[6:0];
            lat_wdata_nxt = s_wdata[15:0];
            state_nxt     = s_we ? RMW_RD : LOAD;
          end
        end
      end
      LOAD: begin
        rvalid_any = 1'b1;
        case (lat_size)
          2'b00:   rdata_int = {24'b0, shifted[7:0]};
          2'b01:   rdata_int = {16'b0, shifted[15:0]};
          default: rdata_int = shifted;
        endcase
        state_nxt = IDLE;
      end
      RMW_RD: begin
        mem_wen     = 1'b1;
        mem_wr_addr = {27'b0, lat_addr[6:2]};
        mem_wr_data = merged;
        state_nxt   = RMW_WR;
      end
      RMW_WR: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Reset is synchronous, so outputs are gated for the whole reset cycle;
    // this also suppresses the RMW write when reset lands in RMW_RD.
    if (!rst) begin
      gnt_any     = 1'b0;
      err_any     = 1'b0;
      rvalid_any  = 1'b0;
      rdata_int   = '0;
      mem_ren     = 1'b0;
      mem_wen     = 1'b0;
      mem_rd_addr = '0;
      mem_wr_addr = '0;
      mem_wr_data = '0;
    end

    p0_gnt    = gnt_any & ~sel;
    p1_gnt    = gnt_any & sel;
    p0_err    = err_any & ~sel;
    p1_err    = err_any & sel;
    p0_rvalid = rvalid_any & ~lat_port;
    p1_rvalid = rvalid_any & lat_port;
    p0_rdata  = (rvalid_any && !lat_port) ? rdata_int : '0;
    p1_rdata  = (rvalid_any && lat_port) ? rdata_int : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal results.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [1:0]  p0_size = '0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [1:0]  p1_size = '0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_rd_addr, mem_wr_addr, mem_wr_data, mem_rd_data;

  logic [31:0] tb_mem [32];
  logic [31:0] ref_mem [32];

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          gnt_cyc [2];
  int          rv_cyc [2];
  logic [31:0] last_rdata [2];
  logic [31:0] last_waddr, last_wdata;
  int          gnt_log [$];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  // Synchronous RAM: read data appears the cycle after mem_ren.
  always @(posedge clk) begin
    if (mem_ren) mem_rd_data <= tb_mem[mem_rd_addr[4:0]];
    if (mem_wen) tb_mem[mem_wr_addr[4:0]] <= mem_wr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic in_req(int p);   return p == 0 ? p0_req   : p1_req;   endfunction
  function automatic logic in_we(int p);    return p == 0 ? p0_we    : p1_we;    endfunction
  function automatic logic [1:0] in_size(int p);   return p == 0 ? p0_size  : p1_size;  endfunction
  function automatic logic [31:0] in_addr(int p);  return p == 0 ? p0_addr  : p1_addr;  endfunction
  function automatic logic [31:0] in_wdata(int p); return p == 0 ? p0_wdata : p1_wdata; endfunction

  // Reference model: tracks how many cycles the arbiter is still busy and the
  // single deferred memory event (load return or RMW write) of the last grant.
  initial begin
    int          busy;
    int          w;
    int          sh;
    logic        last, pend, pend_load, pend_port, fired, illegal;
    logic [31:0] pend_addr, pend_wdata, word, mask, a;
    logic [1:0]  pend_size, s;
    logic [1:0]  e_gnt, e_err, e_rv;
    logic        e_ren, e_wen;
    logic [31:0] e_raddr, e_waddr, e_wdata, e_rdata;
    busy = 0; last = 1'b1; pend = 1'b0; pend_load = 1'b0; pend_port = 1'b0;
    pend_addr = '0; pend_wdata = '0; pend_size = '0;
    forever begin
      @(negedge clk);
      cyc++;
      e_gnt = '0; e_err = '0; e_rv = '0; e_ren = 1'b0; e_wen = 1'b0;
      e_raddr = '0; e_waddr = '0; e_wdata = '0; e_rdata = '0;
      if (!rst) begin
        busy = 0; last = 1'b1; pend = 1'b0;
      end else begin
        if (pend) begin
          word = ref_mem[pend_addr[6:2]];
          sh = 8 * int'(pend_addr[1:0]);
          if (pend_load) begin
            e_rv[pend_port] = 1'b1;
            if (pend_size == 2'd0)      e_rdata = (word >> sh) & 32'h0000_00FF;
            else if (pend_size == 2'd1) e_rdata = (word >> sh) & 32'h0000_FFFF;
            else                        e_rdata = word;
          end else begin
            mask = ((pend_size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
            e_wen = 1'b1;
            e_waddr = {27'b0, pend_addr[6:2]};
            e_wdata = (word & ~mask) | ((pend_wdata << sh) & mask);
            ref_mem[pend_addr[6:2]] = e_wdata;
          end
          pend = 1'b0;
        end
        fired = 1'b0;
        if (busy == 0 && (in_req(0) || in_req(1))) begin
          if (in_req(0) && in_req(1)) w = last ? 0 : 1;
          else                        w = in_req(1) ? 1 : 0;
          e_gnt[w] = 1'b1;
          last = (w == 1);
          a = in_addr(w);
          s = in_size(w);
          illegal = (s == 2'd3) || (s == 2'd1 && a % 2 != 0) ||
                    (s == 2'd2 && a % 4 != 0) || ((a >> 7) != 0);
          if (illegal) begin
            e_err[w] = 1'b1;
          end else if (in_we(w) && s == 2'd2) begin
            e_wen = 1'b1;
            e_waddr = a / 4;
            e_wdata = in_wdata(w);
            ref_mem[a / 4] = in_wdata(w);
          end else begin
            e_ren = 1'b1;
            e_raddr = a / 4;
            pend = 1'b1;
            pend_load = !in_we(w);
            pend_port = (w == 1);
            pend_addr = a;
            pend_size = s;
            pend_wdata = in_wdata(w);
            busy = in_we(w) ? 2 : 1;
            fired = 1'b1;
          end
        end
        if (!fired && busy > 0) busy--;
      end

      check("p0_gnt", p0_gnt, e_gnt[0]);
      check("p1_gnt", p1_gnt, e_gnt[1]);
      check("p0_err", p0_err, e_err[0]);
      check("p1_err", p1_err, e_err[1]);
      check("p0_rvalid", p0_rvalid, e_rv[0]);
      check("p1_rvalid", p1_rvalid, e_rv[1]);
      check("mem_ren", mem_ren, e_ren);
      check("mem_wen", mem_wen, e_wen);
      check("ren_wen_exclusive", mem_ren & mem_wen, 1'b0);
      if (e_ren) check("mem_rd_addr", mem_rd_addr, e_raddr);
      if (e_wen) begin
        check("mem_wr_addr", mem_wr_addr, e_waddr);
        check("mem_wr_data", mem_wr_data, e_wdata);
      end
      if (e_rv[0]) check("p0_rdata", p0_rdata, e_rdata);
      if (e_rv[1]) check("p1_rdata", p1_rdata, e_rdata);
      if (!rst) begin
        check("rst_rd_addr", mem_rd_addr, 32'h0);
        check("rst_wr_addr", mem_wr_addr, 32'h0);
        check("rst_wr_data", mem_wr_data, 32'h0);
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_p1_rdata", p1_rdata, 32'h0);
      end

      if (p0_gnt) begin gnt_cyc[0] = cyc; gnt_log.push_back(0); end
      if (p1_gnt) begin gnt_cyc[1] = cyc; gnt_log.push_back(1); end
      if (p0_rvalid) begin rv_cyc[0] = cyc; last_rdata[0] = p0_rdata; end
      if (p1_rvalid) begin rv_cyc[1] = cyc; last_rdata[1] = p1_rdata; end
      if (mem_wen) begin last_waddr = mem_wr_addr; last_wdata = mem_wr_data; end
    end
  end

  task automatic drive(input int p, input logic r, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin p0_req = r; p0_we = w; p0_size = s; p0_addr = a; p0_wdata = d; end
    else        begin p1_req = r; p1_we = w; p1_size = s; p1_addr = a; p1_wdata = d; end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Holds a request until granted (bounded), returns the err seen with gnt.
  task automatic issue(input int p, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d, output logic e);
    bit done = 1'b0;
    e = 1'b0;
    drive(p, 1'b1, w, s, a, d);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (p == 0 ? p0_gnt : p1_gnt) begin
        done = 1'b1;
        e = (p == 0) ? p0_err : p1_err;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL gnt_timeout: port %0d got no gnt within 50 cycles, required gnt", p);
    end
    sync();
    drive(p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    sync();
    rst = 1'b1;
  endtask

  logic [1:0]  err_size [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
  logic [31:0] err_addr [4] = '{32'h11, 32'h12, 32'h0, 32'h80};

  initial begin
    logic e, e0, e1;
    for (int i = 0; i < 32; i++) begin
      tb_mem[i] = '0;
      ref_mem[i] = '0;
    end
    sync();
    sync();
    rst = 1'b1;

    // Word store then word load
    issue(0, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF, e);
    check("store_wr_addr", last_waddr, 32'd4);
    check("store_wr_data", last_wdata, 32'hDEAD_BEEF);
    issue(0, 1'b0, 2'd2, 32'h10, 32'h0, e);
    @(negedge clk); #1;
    check("load_word_rdata", last_rdata[0], 32'hDEAD_BEEF);
    check("load_latency", rv_cyc[0] - gnt_cyc[0], 32'd1);
    sync();

    // Byte read-modify-write and sub-word loads
    issue(0, 1'b1, 2'd2, 32'h10, 32'h1122_3344, e);
    issue(1, 1'b1, 2'd0, 32'h12, 32'h0000_00AA, e);
    @(negedge clk); #1;
    check("rmw_byte_data", last_wdata, 32'h11AA_3344);
    check("rmw_byte_addr", last_waddr, 32'd4);
    sync();
    issue(1, 1'b0, 2'd0, 32'h12, 32'h0, e);
    @(negedge clk); #1;
    check("load_byte_rdata", last_rdata[1], 32'h0000_00AA);
    sync();
    issue(0, 1'b0, 2'd1, 32'h12, 32'h0, e);
    @(negedge clk); #1;
    check("load_half_hi", last_rdata[0], 32'h0000_11AA);
    sync();
    issue(0, 1'b1, 2'd1, 32'h10, 32'h1234_BEEF, e);
    @(negedge clk); #1;
    check("rmw_half_lo", last_wdata, 32'h11AA_BEEF);
    sync();
    issue(1, 1'b0, 2'd0, 32'h7F, 32'h0, e);
    @(negedge clk); #1;
    check("load_top_byte", last_rdata[1], 32'h0);
    sync();

    // Rejected requests
    for (int i = 0; i < 4; i++) begin
      issue(0, i[0], err_size[i], err_addr[i], 32'h5A5A_5A5A, e);
      check("err_pulse", e, 1'b1);
    end

    // Reset landing in RMW_RD of a byte store
    issue(1, 1'b1, 2'd0, 32'h13, 32'h0000_0055, e);
    rst = 1'b0;
    sync();
    rst = 1'b1;
    issue(0, 1'b0, 2'd2, 32'h10, 32'h0, e);
    @(negedge clk); #1;
    check("word_after_abort", last_rdata[0], 32'h11AA_BEEF);
    sync();

    // Contention with continuous word stores
    pulse_reset();
    gnt_log.delete();
    fork
      for (int k = 0; k < 3; k++) issue(0, 1'b1, 2'd2, 32'h20 + 32'(4 * k), 32'hA0 + 32'(k), e0);
      for (int k = 0; k < 3; k++) issue(1, 1'b1, 2'd2, 32'h40 + 32'(4 * k), 32'hB0 + 32'(k), e1);
    join
    check("contention_count", gnt_log.size(), 32'd6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++)
      check("contention_order", gnt_log[i], i % 2);

    // Load on p0 blocks p1
    pulse_reset();
    fork
      issue(0, 1'b0, 2'd2, 32'h20, 32'h0, e0);
      issue(1, 1'b0, 2'd2, 32'h24, 32'h0, e1);
    join
    @(negedge clk); #1;
    check("block_p0_rdata", last_rdata[0], 32'hA0);
    check("block_p1_rdata", last_rdata[1], 32'hA1);
    check("block_p1_after_rvalid", gnt_cyc[1] > rv_cyc[0], 1'b1);
    sync();
    sync();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation reached time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
